// File: rtl/approx_err_eval_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// approx_eval_pkg
// Shared definitions for the approximate-adder error evaluator:
//   - default values for the adder geometry (N_IN, N_OUT) and error threshold
//   - FSM state encoding used by approx_err_eval_ctrl
// No ports; imported by approx_err_eval_ctrl and abs_err_unit.
// ---------------------------------------------------------------------------
package approx_eval_pkg;

  // Default adder geometry: N_IN input bits (two N_IN/2-bit operands),
  // N_OUT = N_IN/2 + 1 output bits so the exact sum never overflows.
  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 3;

  // Default maximum tolerated absolute error.
  localparam int DEF_ET    = 1;

  // Controller state encoding.
  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/approx_err_eval_ctrl_abs_err_unit.sv
// ---------------------------------------------------------------------------
// abs_err_unit
// Purely combinational error calculator for one stimulus vector.
// Ports:
//   a, b     : operands (N_IN/2 bits each)
//   dut_out  : response of the approximate adder (N_OUT bits)
//   exact    : exact a+b (N_OUT bits, cannot overflow)
//   err      : |dut_out - exact|
//   over_et  : err > ET
// ---------------------------------------------------------------------------
module abs_err_unit
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int ET    = DEF_ET
) (
  input  logic [N_IN/2-1:0] a,
  input  logic [N_IN/2-1:0] b,
  input  logic [N_OUT-1:0]  dut_out,
  output logic [N_OUT-1:0]  exact,
  output logic [N_OUT-1:0]  err,
  output logic              over_et
);

  localparam int unsigned ET_U = ET;

  // Operands are zero-extended to the output width before adding; N_OUT is
  // one bit wider than an operand so the carry is always kept.
  always_comb begin
    exact   = N_OUT'(a) + N_OUT'(b);
    err     = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
    // Compare at 32 bits so a threshold wider than err cannot truncate.
    over_et = (32'(err) > ET_U);
  end

endmodule

// File: rtl/approx_err_eval_ctrl.sv
// ---------------------------------------------------------------------------
// approx_err_eval_ctrl
// Exhaustively drives all 2^N_IN input vectors into an external approximate
// adder and accumulates error statistics against the exact sum.
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   start       : request one evaluation run (accepted only in IDLE)
//   busy        : run in progress (RUN, FLUSH, DONE)
//   done        : one-cycle pulse, results valid
//   dut_in      : registered stimulus {b, a} to the approximate adder
//   dut_out     : combinational adder response to dut_in
//   max_err     : largest absolute error of the run
//   sum_err     : sum of absolute errors of the run
//   fail_cnt    : number of vectors whose error exceeds ET
//   first_fail  : lowest failing vector, 0 if none
//   pass        : max_err <= ET, valid from done until the next accepted start
// ---------------------------------------------------------------------------
module approx_err_eval_ctrl
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int ET    = DEF_ET
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN-1:0]       dut_in,
  input  logic [N_OUT-1:0]      dut_out,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_IN+N_OUT-1:0] sum_err,
  output logic [N_IN:0]         fail_cnt,
  output logic [N_IN-1:0]       first_fail,
  output logic                  pass
);

  localparam int HALF = N_IN / 2;
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam int unsigned ET_U = ET;

  state_t state;
  state_t state_next;

  logic [N_IN-1:0]  vec;
  logic             s1_valid;
  logic [N_IN-1:0]  s1_vec;
  logic [N_OUT-1:0] s1_out;

  logic [N_OUT-1:0] exact;
  logic [N_OUT-1:0] err;
  logic             over_et;
  logic [N_OUT-1:0] max_next;
  logic             start_accept;

  assign start_accept = (state == ST_IDLE) && start;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  // The counter wraps back to 0 after the last vector, so dut_in is simply
  // the counter register and naturally reads 0 outside RUN.
  assign dut_in = vec;

  abs_err_unit #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .ET    (ET)
  ) u_abs_err (
    .a       (s1_vec[HALF-1:0]),
    .b       (s1_vec[N_IN-1:HALF]),
    .dut_out (s1_out),
    .exact   (exact),
    .err     (err),
    .over_et (over_et)
  );

  // Running maximum including the vector currently in stage 2; also used to
  // register pass on the FLUSH cycle, when the last vector is accumulated.
  always_comb begin
    max_next = max_err;
    if (s1_valid && (err > max_err)) begin
      max_next = err;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)           state_next = ST_RUN;
      ST_RUN:   if (vec == VEC_LAST) state_next = ST_FLUSH;
      ST_FLUSH:                      state_next = ST_DONE;
      ST_DONE:                       state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else if (start_accept) begin
      vec <= '0;
    end else if (state == ST_RUN) begin
      vec <= vec + N_IN'(1);
    end
  end

  // Stage 1: capture the stimulus together with the adder response so the
  // error arithmetic sits in its own cycle, off the adder's combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_out   <= '0;
    end else begin
      s1_valid <= (state == ST_RUN);
      s1_vec   <= vec;
      s1_out   <= dut_out;
    end
  end

  // Stage 2 accumulators. Vectors arrive in ascending order, so the first
  // failure seen (fail_cnt still 0) is also the lowest failing vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err    <= '0;
      sum_err    <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else if (start_accept) begin
      max_err    <= '0;
      sum_err    <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else if (s1_valid) begin
      max_err <= max_next;
      sum_err <= sum_err + (N_IN+N_OUT)'(err);
      if (over_et) begin
        fail_cnt <= fail_cnt + (N_IN+1)'(1);
        if (fail_cnt == '0) begin
          first_fail <= s1_vec;
        end
      end
    end
  end

  // pass becomes valid together with done and then holds through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (start_accept) begin
      pass <= 1'b0;
    end else if (state == ST_FLUSH) begin
      pass <= (32'(max_next) <= ET_U);
    end
  end

endmodule

// File: tb/tb_approx_err_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_approx_err_eval_ctrl
// Directed bench for approx_err_eval_ctrl with default parameters
// (N_IN=4, N_OUT=3, ET=1). A behavioural adder model selected by `model`
// answers dut_in combinationally:
//   0 : exact a+b
//   1 : constant 0
//   2 : exact a+b plus 1
// ---------------------------------------------------------------------------
module tb_approx_err_eval_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] dut_in;
  logic [2:0] dut_out;
  logic [2:0] max_err;
  logic [6:0] sum_err;
  logic [4:0] fail_cnt;
  logic [3:0] first_fail;
  logic       pass;

  int model;
  int tests_run;
  int tests_failed;

  int done_off;
  int busy_gaps;
  int done_pulses;
  int vec_errs;
  int cleared;
  int rst_done;

  approx_err_eval_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .max_err    (max_err),
    .sum_err    (sum_err),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail),
    .pass       (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Approximate adder models.
  always_comb begin
    logic [2:0] ex;
    ex = {1'b0, dut_in[1:0]} + {1'b0, dut_in[3:2]};
    case (model)
      1:       dut_out = 3'd0;
      2:       dut_out = ex + 3'd1;
      default: dut_out = ex;
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle (cycle S), then watches cycles S+1..S+24.
  // restart_at > 0 raises start again during cycle S+restart_at.
  task automatic apply_stimulus(input int mdl, input int restart_at);
    model = mdl;
    @(negedge clk);
    start       = 1'b1;
    done_off    = -1;
    busy_gaps   = 0;
    done_pulses = 0;
    vec_errs    = 0;
    cleared     = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == 1) begin
        cleared = (max_err == 3'd0 && sum_err == 7'd0 && fail_cnt == 5'd0 &&
                   first_fail == 4'd0 && pass == 1'b0) ? 1 : 0;
      end
      if (done) begin
        done_pulses++;
        if (done_off < 0) done_off = k;
      end
      if (k <= 18 && !busy) busy_gaps++;
      if (k <= 16) begin
        if (dut_in !== 4'(k - 1)) vec_errs++;
      end else if (dut_in !== 4'd0) begin
        vec_errs++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model        = 0;
    start        = 1'b0;
    rst_n        = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst_busy",       32'(busy),       32'd0);
    check_output("rst_done",       32'(done),       32'd0);
    check_output("rst_pass",       32'(pass),       32'd0);
    check_output("rst_dut_in",     32'(dut_in),     32'd0);
    check_output("rst_max_err",    32'(max_err),    32'd0);
    check_output("rst_sum_err",    32'(sum_err),    32'd0);
    check_output("rst_fail_cnt",   32'(fail_cnt),   32'd0);
    check_output("rst_first_fail", 32'(first_fail), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exact adder: no error at all.
    apply_stimulus(0, 0);
    check_output("exact_cleared",    32'(cleared),     32'd1);
    check_output("exact_done_cycle", 32'(done_off),    32'd18);
    check_output("exact_done_count", 32'(done_pulses), 32'd1);
    check_output("exact_busy_gaps",  32'(busy_gaps),   32'd0);
    check_output("exact_vec_seq",    32'(vec_errs),    32'd0);
    check_output("exact_busy_after", 32'(busy),        32'd0);
    check_output("exact_max_err",    32'(max_err),     32'd0);
    check_output("exact_sum_err",    32'(sum_err),     32'd0);
    check_output("exact_fail_cnt",   32'(fail_cnt),    32'd0);
    check_output("exact_first_fail", 32'(first_fail),  32'd0);
    check_output("exact_pass",       32'(pass),        32'd1);

    // Output tied to 0: err = a+b; sum 24+24, 13 vectors have a+b > 1,
    // lowest is vec 2 (a=2, b=0).
    apply_stimulus(1, 0);
    check_output("zero_done_cycle", 32'(done_off),   32'd18);
    check_output("zero_max_err",    32'(max_err),    32'd6);
    check_output("zero_sum_err",    32'(sum_err),    32'd48);
    check_output("zero_fail_cnt",   32'(fail_cnt),   32'd13);
    check_output("zero_first_fail", 32'(first_fail), 32'd2);
    check_output("zero_pass",       32'(pass),       32'd0);

    // Back-to-back: exact+1 right after the failing run; results restart.
    apply_stimulus(2, 0);
    check_output("plus1_cleared",    32'(cleared),    32'd1);
    check_output("plus1_done_cycle", 32'(done_off),   32'd18);
    check_output("plus1_max_err",    32'(max_err),    32'd1);
    check_output("plus1_sum_err",    32'(sum_err),    32'd16);
    check_output("plus1_fail_cnt",   32'(fail_cnt),   32'd0);
    check_output("plus1_first_fail", 32'(first_fail), 32'd0);
    check_output("plus1_pass",       32'(pass),       32'd1);

    // Second start while busy must be ignored.
    apply_stimulus(0, 5);
    check_output("dbl_done_cycle", 32'(done_off),    32'd18);
    check_output("dbl_done_count", 32'(done_pulses), 32'd1);
    check_output("dbl_busy_gaps",  32'(busy_gaps),   32'd0);
    check_output("dbl_pass",       32'(pass),        32'd1);

    // Start during the done cycle must be ignored.
    apply_stimulus(0, 18);
    check_output("donestart_count", 32'(done_pulses), 32'd1);
    check_output("donestart_busy",  32'(busy),        32'd0);

    // Reset in cycle 8 of a failing run.
    model = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy",       32'(busy),       32'd0);
    check_output("midrst_done",       32'(done),       32'd0);
    check_output("midrst_dut_in",     32'(dut_in),     32'd0);
    check_output("midrst_sum_err",    32'(sum_err),    32'd0);
    check_output("midrst_max_err",    32'(max_err),    32'd0);
    check_output("midrst_fail_cnt",   32'(fail_cnt),   32'd0);
    check_output("midrst_first_fail", 32'(first_fail), 32'd0);
    check_output("midrst_pass",       32'(pass),       32'd0);
    rst_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    check_output("midrst_no_done", 32'(rst_done), 32'd0);

    apply_stimulus(2, 0);
    check_output("postrst_done_cycle", 32'(done_off),   32'd18);
    check_output("postrst_vec_seq",    32'(vec_errs),   32'd0);
    check_output("postrst_max_err",    32'(max_err),    32'd1);
    check_output("postrst_sum_err",    32'(sum_err),    32'd16);
    check_output("postrst_fail_cnt",   32'(fail_cnt),   32'd0);
    check_output("postrst_pass",       32'(pass),       32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/approx_err_eval_ctrl.md
APPROX_ERR_EVAL_CTRL -- requirements
Module: approx_err_eval_ctrl

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the approximate adder input count; N_IN SHALL be even.
REQ-002 The block SHALL have parameter N_OUT, default 3, meaning the approximate adder output count; N_OUT SHALL equal N_IN/2+1.
REQ-003 The block SHALL have parameter ET, default 1, meaning the maximum allowed absolute error.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request for one exhaustive evaluation run.
REQ-007 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse, results valid.
REQ-009 The block SHALL have port dut_in, output, N_IN bits: registered stimulus to the approximate adder; bits [N_IN/2-1:0] form operand a, bits [N_IN-1:N_IN/2] form operand b.
REQ-010 The block SHALL have port dut_out, input, N_OUT bits: combinational response of the approximate adder to dut_in.
REQ-011 The block SHALL have port max_err, output, N_OUT bits: largest |dut_out - (a+b)| over the run.
REQ-012 The block SHALL have port sum_err, output, N_IN+N_OUT bits: sum of absolute errors over the run.
REQ-013 The block SHALL have port fail_cnt, output, N_IN+1 bits: number of vectors with error > ET.
REQ-014 The block SHALL have port first_fail, output, N_IN bits: lowest failing vector; 0 when none.
REQ-015 The block SHALL have port pass, output, 1 bit: max_err <= ET, valid from done until the next accepted start.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, FLUSH, DONE.
REQ-017 IDLE: start=1 SHALL go to RUN, clear all result outputs and the vector counter, and drop pass to 0.
REQ-018 RUN: dut_in SHALL equal the vector counter vec, which increments by 1 each cycle from 0 to 2^N_IN-1; after vec=2^N_IN-1, go to FLUSH.
REQ-019 Each RUN cycle, stage-1 registers SHALL capture {vec, dut_out} with a valid bit.
REQ-020 Stage 2 SHALL compute exact = a+b (N_OUT bits, no overflow) and err = |dut_out - exact| from stage 1, and update accumulators at the end of the same cycle.
REQ-021 Accumulator update: max_err = max(max_err, err); sum_err += err; if err > ET, fail_cnt += 1, and first_fail is loaded if this is the first failure of the run.
REQ-022 FLUSH SHALL last exactly one cycle, accumulating the last vector, then go to DONE.
REQ-023 DONE SHALL assert done for one cycle, register pass, and return to IDLE.
REQ-024 If start is sampled in cycle S, done SHALL be high in cycle S+2^N_IN+2 (cycle S+18 for defaults).
REQ-025 busy SHALL be 1 in RUN, FLUSH and DONE, and 0 in IDLE.
REQ-026 start SHALL be ignored while busy=1; start in the same cycle as done SHALL be ignored.
REQ-027 Results SHALL hold their values in IDLE until the next accepted start.
REQ-028 dut_in SHALL hold 0 outside RUN.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and set busy, done, pass, dut_in, max_err, sum_err, fail_cnt, first_fail, the stage-1 valid bit and vec to 0.
REQ-030 Reset mid-run SHALL abort the run without a done pulse; a new start after release SHALL begin a fresh run from vec 0.

Structure
REQ-031 Shared package approx_eval_pkg SHALL hold the FSM state enum and the default values of N_IN, N_OUT and ET.
REQ-032 Sub-module abs_err_unit SHALL be combinational: from a, b and dut_out it produces exact, err and the err>ET flag; all registers stay in the top module.

Verification
REQ-033 Exact adder on dut_out, start at cycle 0 -> done at cycle 18, max_err=0, sum_err=0, fail_cnt=0, first_fail=0, pass=1.
REQ-034 dut_out tied to 0 -> max_err=6, sum_err=48, fail_cnt=13, first_fail=2, pass=0.
REQ-035 dut_out = exact+1 -> max_err=1, sum_err=16, fail_cnt=0, pass=1 (ET=1).
REQ-036 start pulsed at cycles 0 and 5 with an exact DUT -> exactly one done, at cycle 18, and busy continuously high from cycle 1 to 18.
REQ-037 rst_n low at cycle 8 of a run -> all outputs 0 at once, no done; start after release -> done 18 cycles later with correct results.
REQ-038 Back-to-back runs with a different DUT model in each -> second-run results cleared at its start and independent of the first run.
